pattern_tx: RTL and testbench

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_tx_pkg.sv | 15 +
 rtl/pattern_shreg.sv | 39 +++
 rtl/pattern_tx.sv | 152 +++++++++++++++
 tb/tb_pattern_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
// rtl/pattern_tx_pkg.sv - shared state encoding and default sizes for pattern_tx
package pattern_tx_pkg;

    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_REP_W   = 4;
    localparam int DEF_GAP_W   = 4;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SHIFT = 4'b0010,
        ST_GAP   = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

endpackage

// File: rtl/pattern_shreg.sv
// rtl/pattern_shreg.sv - loadable MSB-first shift register with bit index
module pattern_shreg #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] data,
    input  logic [LEN_W-1:0]   len,
    output logic               nxt_bit,
    output logic               last
);

    logic [MAX_LEN-1:0] sreg;
    logic [MAX_LEN-1:0] aligned;
    logic [LEN_W-1:0]   idx;

    // Bit len-1 is moved to the top so every bit leaves from the same position.
    // The register keeps only the bits still to come after the one being emitted.
    assign aligned = data << (LEN_W'(MAX_LEN) - len);
    assign nxt_bit = load ? aligned[MAX_LEN-1] : sreg[MAX_LEN-1];
    assign last    = (idx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= aligned << 1;
            idx  <= len - 1'b1;
        end else if (shift) begin
            sreg <= sreg << 1;
            idx  <= idx - 1'b1;
        end
    end

endmodule

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - repeating serial pattern transmitter with inter-repeat gaps
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int REP_W   = DEF_REP_W,
    parameter int GAP_W   = DEF_GAP_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [MAX_LEN-1:0]         pattern,
    input  logic [$clog2(MAX_LEN):0]   len,
    input  logic [REP_W-1:0]           rep,
    input  logic [GAP_W-1:0]           gap,
    output logic                       sout,
    output logic                       sout_vld,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    state_t             state, state_n;
    logic [MAX_LEN-1:0] pat_c;
    logic [LEN_W-1:0]   len_c;
    logic [REP_W-1:0]   rep_cnt;
    logic [GAP_W-1:0]   gap_c;
    logic [GAP_W-1:0]   gap_cnt;
    logic [LEN_W-1:0]   len_clamp;
    logic [MAX_LEN-1:0] ld_data;
    logic [LEN_W-1:0]   ld_len;
    logic               ld, sh, capture, rep_dec, gap_load, err_n;
    logic               nxt_bit, last;

    assign len_clamp = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    // The first load happens in the same edge as capture, so it bypasses the copies.
    assign ld_data   = (state == ST_IDLE) ? pattern   : pat_c;
    assign ld_len    = (state == ST_IDLE) ? len_clamp : len_c;

    pattern_shreg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load    (ld),
        .shift   (sh),
        .data    (ld_data),
        .len     (ld_len),
        .nxt_bit (nxt_bit),
        .last    (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        ld       = 1'b0;
        sh       = 1'b0;
        capture  = 1'b0;
        rep_dec  = 1'b0;
        gap_load = 1'b0;
        err_n    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    if (len == '0) begin
                        state_n = ST_DONE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = ST_SHIFT;
                        ld      = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (!last) begin
                    sh = 1'b1;
                end else if (rep_cnt != '0) begin
                    rep_dec = 1'b1;
                    if (gap_c != '0) begin
                        state_n  = ST_GAP;
                        gap_load = 1'b1;
                    end else begin
                        ld = 1'b1;
                    end
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_n = ST_SHIFT;
                    ld      = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_c   <= '0;
            len_c   <= '0;
            rep_cnt <= '0;
            gap_c   <= '0;
            gap_cnt <= '0;
        end else begin
            if (capture) begin
                pat_c   <= pattern;
                len_c   <= len_clamp;
                rep_cnt <= rep;
                gap_c   <= gap;
            end else if (rep_dec) begin
                rep_cnt <= rep_cnt - 1'b1;
            end
            if (gap_load) begin
                gap_cnt <= gap_c;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sout     <= 1'b0;
            sout_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            sout     <= (state_n == ST_SHIFT) && nxt_bit;
            sout_vld <= (state_n == ST_SHIFT);
            busy     <= (state_n == ST_SHIFT) || (state_n == ST_GAP);
            done     <= (state_n == ST_DONE);
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - directed self-checking bench for pattern_tx
module tb_pattern_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  rep;
    logic [3:0]  gap;
    logic        sout, sout_vld, busy, done, err;

    int total = 0;
    int bad   = 0;

    pattern_tx dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .len      (len),
        .rep      (rep),
        .gap      (gap),
        .sout     (sout),
        .sout_vld (sout_vld),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic s,
                           input logic b, input logic d, input logic e);
        chk({tag, ".vld"},  {31'd0, sout_vld}, {31'd0, v});
        chk({tag, ".sout"}, {31'd0, sout},     {31'd0, s});
        chk({tag, ".busy"}, {31'd0, busy},     {31'd0, b});
        chk({tag, ".done"}, {31'd0, done},     {31'd0, d});
        chk({tag, ".err"},  {31'd0, err},      {31'd0, e});
    endtask

    task automatic cyc(input string tag, input logic v, input logic s,
                       input logic b, input logic d, input logic e);
        @(posedge clk);
        #1;
        chk_all(tag, v, s, b, d, e);
    endtask

    task automatic kick(input logic [15:0] p, input logic [4:0] l,
                        input logic [3:0] r, input logic [3:0] g);
        pattern = p;
        len     = l;
        rep     = r;
        gap     = g;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    logic [7:0]  a5_bits;
    logic [15:0] wide_bits;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        rep     = '0;
        gap     = '0;
        @(posedge clk);
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc("idle", 0, 0, 0, 0, 0);

        // 3-bit single shot: 1,0,1 then done
        kick(16'h0005, 5'd3, 4'd0, 4'd0);
        chk_all("p3.b0", 1, 1, 1, 0, 0);
        cyc("p3.b1", 1, 0, 1, 0, 0);
        cyc("p3.b2", 1, 1, 1, 0, 0);
        cyc("p3.done", 0, 0, 0, 1, 0);
        cyc("p3.idle", 0, 0, 0, 0, 0);

        // one repeat with a two-cycle gap
        kick(16'h0005, 5'd3, 4'd1, 4'd2);
        chk_all("g2.r0b0", 1, 1, 1, 0, 0);
        cyc("g2.r0b1", 1, 0, 1, 0, 0);
        cyc("g2.r0b2", 1, 1, 1, 0, 0);
        cyc("g2.gap0", 0, 0, 1, 0, 0);
        cyc("g2.gap1", 0, 0, 1, 0, 0);
        cyc("g2.r1b0", 1, 1, 1, 0, 0);
        cyc("g2.r1b1", 1, 0, 1, 0, 0);
        cyc("g2.r1b2", 1, 1, 1, 0, 0);
        cyc("g2.done", 0, 0, 0, 1, 0);
        cyc("g2.idle", 0, 0, 0, 0, 0);

        // zero length: immediate done with err, never busy
        kick(16'hFFFF, 5'd0, 4'd3, 4'd1);
        chk_all("len0.done", 0, 0, 0, 1, 1);
        cyc("len0.idle", 0, 0, 0, 0, 0);

        // start re-pulsed mid-run and in DONE, inputs changed mid-run
        a5_bits = 8'hA5;
        kick(16'h00A5, 5'd8, 4'd0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                cyc($sformatf("ign.b%0d", i), 1, a5_bits[7-i], 1, 0, 0);
            end else begin
                chk_all("ign.b0", 1, a5_bits[7], 1, 0, 0);
            end
            if (i == 0) begin
                start   = 1'b1;
                pattern = 16'h5A5A;
                len     = 5'd3;
                rep     = 4'd5;
                gap     = 4'd7;
            end else if (i == 1) begin
                start = 1'b0;
            end
        end
        cyc("ign.done", 0, 0, 0, 1, 0);
        start = 1'b1;
        cyc("ign.post", 0, 0, 0, 0, 0);
        start = 1'b0;
        cyc("ign.idle", 0, 0, 0, 0, 0);

        // reset in the middle of a run aborts it
        kick(16'h00A5, 5'd8, 4'd0, 4'd0);
        chk_all("rst.b0", 1, 1, 1, 0, 0);
        cyc("rst.b1", 1, 0, 1, 0, 0);
        rst = 1'b1;
        #1;
        chk_all("rst.async", 0, 0, 0, 0, 0);
        cyc("rst.hold", 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("rst.wait%0d", i), 0, 0, 0, 0, 0);
        end
        kick(16'h0005, 5'd3, 4'd0, 4'd0);
        chk_all("rst.n0", 1, 1, 1, 0, 0);
        cyc("rst.n1", 1, 0, 1, 0, 0);
        cyc("rst.n2", 1, 1, 1, 0, 0);
        cyc("rst.ndone", 0, 0, 0, 1, 0);

        // over-long len clamps to 16 bits
        wide_bits = 16'h8001;
        cyc("clamp.pre", 0, 0, 0, 0, 0);
        kick(16'h8001, 5'd20, 4'd0, 4'd0);
        chk_all("clamp.b0", 1, wide_bits[15], 1, 0, 0);
        for (int i = 1; i < 16; i++) begin
            cyc($sformatf("clamp.b%0d", i), 1, wide_bits[15-i], 1, 0, 0);
        end
        cyc("clamp.done", 0, 0, 0, 1, 0);

        // maximum repeat count gives 16 back-to-back single-bit transmissions
        cyc("rmax.pre", 0, 0, 0, 0, 0);
        kick(16'h0001, 5'd1, 4'd15, 4'd0);
        chk_all("rmax.t0", 1, 1, 1, 0, 0);
        for (int i = 1; i < 16; i++) begin
            cyc($sformatf("rmax.t%0d", i), 1, 1, 1, 0, 0);
        end
        cyc("rmax.done", 0, 0, 0, 1, 0);
        cyc("rmax.idle", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
